// File: rtl/univ_shift_reg_if.sv
// rtl/univ_shift_reg_if.sv - control, serial and parallel signal bundle for univ_shift_reg
interface univ_shift_reg_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic [1:0]       mode;
  logic             sin_r;
  logic             sin_l;
  logic [WIDTH-1:0] pin;
  logic [WIDTH-1:0] q;
  logic             sout_r;
  logic             sout_l;
  logic             frame_done;

  modport master (
    output en, mode, sin_r, sin_l, pin,
    input  q, sout_r, sout_l, frame_done
  );

  modport slave (
    input  en, mode, sin_r, sin_l, pin,
    output q, sout_r, sout_l, frame_done
  );
endinterface

// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - universal shift register: hold / shift right / shift left / load, with frame pulse
module univ_shift_reg #(
  parameter int               WIDTH  = 8,
  parameter bit               ROTATE = 1'b0,
  parameter logic [WIDTH-1:0] INIT   = {WIDTH{1'b0}}
) (
  input logic             clk,
  input logic             rst,
  univ_shift_reg_if.slave sr
);
  localparam int              CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {COUNTING = 1'b0, LAST = 1'b1} frame_state_t;

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  logic [WIDTH-1:0] q, q_next;
  logic [CW-1:0]    cnt, cnt_next, cnt_inc;
  frame_state_t     state, state_next;
  logic             done, done_next;
  logic             shift;
  logic             in_r, in_l;

  always_ff @(posedge clk) begin
    if (rst) begin
      q     <= INIT;
      cnt   <= '0;
      state <= COUNTING;
      done  <= 1'b0;
    end else begin
      q     <= q_next;
      cnt   <= cnt_next;
      state <= state_next;
      done  <= done_next;
    end
  end

  always_comb begin
    q_next     = q;
    cnt_next   = cnt;
    state_next = state;
    done_next  = 1'b0;
    shift      = 1'b0;
    cnt_inc    = cnt + 1'b1;
    // in rotate mode the end bit recirculates and the serial inputs are ignored
    in_r       = ROTATE ? q[0]       : sr.sin_r;
    in_l       = ROTATE ? q[WIDTH-1] : sr.sin_l;

    if (sr.en) begin
      case (sr.mode)
        MODE_RIGHT: begin
          q_next = {in_r, q[WIDTH-1:1]};
          shift  = 1'b1;
        end
        MODE_LEFT: begin
          q_next = {q[WIDTH-2:0], in_l};
          shift  = 1'b1;
        end
        MODE_LOAD: begin
          q_next     = sr.pin;
          cnt_next   = '0;
          state_next = COUNTING;
        end
        MODE_HOLD: ;
        default: ;
      endcase
    end

    // either direction advances the same frame count
    if (shift) begin
      if (state == LAST) begin
        cnt_next   = '0;
        state_next = COUNTING;
        done_next  = 1'b1;
      end else begin
        cnt_next   = cnt_inc;
        state_next = (cnt_inc == LAST_CNT) ? LAST : COUNTING;
      end
    end
  end

  assign sr.q          = q;
  assign sr.sout_r     = q[0];
  assign sr.sout_l     = q[WIDTH-1];
  assign sr.frame_done = done;
endmodule

// File: tb/tb_univ_shift_reg.sv
// tb/tb_univ_shift_reg.sv - directed vector bench for univ_shift_reg
module tb_univ_shift_reg;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  univ_shift_reg_if #(.WIDTH(8)) bus_a ();
  univ_shift_reg_if #(.WIDTH(8)) bus_r ();

  univ_shift_reg #(.WIDTH(8), .ROTATE(1'b0), .INIT(8'hA5)) dut_a (
    .clk (clk),
    .rst (rst),
    .sr  (bus_a)
  );

  univ_shift_reg #(.WIDTH(8), .ROTATE(1'b1), .INIT(8'h00)) dut_r (
    .clk (clk),
    .rst (rst),
    .sr  (bus_r)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic       sin_r;
    logic       sin_l;
    logic [7:0] pin;
    logic [7:0] exp_q;
    logic       exp_done;
  } vec_t;

  vec_t vecs[64];
  int   nvec  = 0;
  int   tests = 0;
  int   fails = 0;

  task automatic add(input logic r, input logic e, input logic [1:0] m, input logic sr_b,
                     input logic sl_b, input logic [7:0] p, input logic [7:0] eq, input logic ed);
    vecs[nvec] = '{rst: r, en: e, mode: m, sin_r: sr_b, sin_l: sl_b, pin: p, exp_q: eq, exp_done: ed};
    nvec++;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_a(input logic r, input logic e, input logic [1:0] m, input logic sr_b,
                         input logic sl_b, input logic [7:0] p);
    rst         = r;
    bus_a.en    = e;
    bus_a.mode  = m;
    bus_a.sin_r = sr_b;
    bus_a.sin_l = sl_b;
    bus_a.pin   = p;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_r(input logic e, input logic [1:0] m, input logic [7:0] p);
    bus_r.en    = e;
    bus_r.mode  = m;
    bus_r.sin_r = 1'b0;
    bus_r.sin_l = 1'b0;
    bus_r.pin   = p;
    @(posedge clk);
    #1;
  endtask

  // n enabled shifts on dut_a; records the shift index of the first two pulses
  task automatic run_shifts(input int n, input bit alt, output int npulse, output int p1, output int p2);
    npulse = 0;
    p1     = -1;
    p2     = -1;
    for (int i = 1; i <= n; i++) begin
      drive_a(1'b0, 1'b1, (alt && (i % 2 == 0)) ? 2'b10 : 2'b01, i[0], ~i[0], 8'h00);
      if (bus_a.frame_done) begin
        npulse++;
        if (p1 < 0) p1 = i;
        else if (p2 < 0) p2 = i;
      end
    end
  endtask

  initial begin
    logic [7:0] right_q [8];
    logic       right_in [8];
    logic [7:0] lq;
    int         np, p1, p2;

    right_q  = '{8'hE1, 8'h70, 8'hB8, 8'hDC, 8'h6E, 8'h37, 8'h9B, 8'h4D};
    right_in = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    bus_a.en = 1'b0; bus_a.mode = 2'b00; bus_a.sin_r = 1'b0; bus_a.sin_l = 1'b0; bus_a.pin = 8'h00;
    bus_r.en = 1'b0; bus_r.mode = 2'b00; bus_r.sin_r = 1'b0; bus_r.sin_l = 1'b0; bus_r.pin = 8'h00;

    add(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 8'hA5, 1'b0);
    add(1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 8'h00, 8'hA5, 1'b0);
    add(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 8'hC3, 8'hC3, 1'b0);
    for (int i = 0; i < 8; i++)
      add(1'b0, 1'b1, 2'b01, right_in[i], 1'b0, 8'h00, right_q[i], (i == 7));
    add(1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 8'hFF, 8'h4D, 1'b0);
    add(1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 8'h12, 8'h4D, 1'b0);
    add(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    lq = 8'h00;
    for (int i = 0; i < 8; i++) begin
      lq = {lq[6:0], 1'b1};
      add(1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 8'h00, lq, (i == 7));
      add(1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 8'h00, lq, 1'b0);
    end

    for (int i = 0; i < nvec; i++) begin
      drive_a(vecs[i].rst, vecs[i].en, vecs[i].mode, vecs[i].sin_r, vecs[i].sin_l, vecs[i].pin);
      check($sformatf("vec%0d q", i), 64'(bus_a.q), 64'(vecs[i].exp_q));
      check($sformatf("vec%0d sout_r", i), 64'(bus_a.sout_r), 64'(vecs[i].exp_q[0]));
      check($sformatf("vec%0d sout_l", i), 64'(bus_a.sout_l), 64'(vecs[i].exp_q[7]));
      check($sformatf("vec%0d frame_done", i), 64'(bus_a.frame_done), 64'(vecs[i].exp_done));
    end

    // load while cnt==7: no pulse, and a fresh frame starts
    drive_a(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 8'h00);
    run_shifts(7, 1'b0, np, p1, p2);
    check("pre_load pulses", 64'(np), 64'd0);
    drive_a(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 8'h5A);
    check("load_at_last q", 64'(bus_a.q), 64'h5A);
    check("load_at_last done", 64'(bus_a.frame_done), 64'd0);
    drive_a(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 8'h00);
    check("load_at_last done+1", 64'(bus_a.frame_done), 64'd0);

    run_shifts(16, 1'b0, np, p1, p2);
    check("b2b pulses", 64'(np), 64'd2);
    check("b2b first", 64'(p1), 64'd8);
    check("b2b second", 64'(p2), 64'd16);

    // reset while cnt==7 and a shift is requested
    run_shifts(7, 1'b0, np, p1, p2);
    drive_a(1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 8'h00);
    check("rst_at_last q", 64'(bus_a.q), 64'hA5);
    check("rst_at_last done", 64'(bus_a.frame_done), 64'd0);
    drive_a(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 8'h00);
    check("rst_at_last done+1", 64'(bus_a.frame_done), 64'd0);
    run_shifts(8, 1'b0, np, p1, p2);
    check("post_rst pulse at", 64'(p1), 64'd8);

    run_shifts(16, 1'b1, np, p1, p2);
    check("alt pulses", 64'(np), 64'd2);
    check("alt first", 64'(p1), 64'd8);
    check("alt second", 64'(p2), 64'd16);

    // rotate instance: serial inputs held at 0 must be ignored
    drive_r(1'b1, 2'b11, 8'h81);
    check("rot load", 64'(bus_r.q), 64'h81);
    drive_r(1'b1, 2'b01, 8'h00); check("rot r1", 64'(bus_r.q), 64'hC0);
    drive_r(1'b1, 2'b01, 8'h00); check("rot r2", 64'(bus_r.q), 64'h60);
    drive_r(1'b1, 2'b01, 8'h00); check("rot r3", 64'(bus_r.q), 64'h30);
    drive_r(1'b1, 2'b10, 8'h00); check("rot l1", 64'(bus_r.q), 64'h60);
    drive_r(1'b1, 2'b10, 8'h00); check("rot l2", 64'(bus_r.q), 64'hC0);
    drive_r(1'b1, 2'b10, 8'h00); check("rot l3", 64'(bus_r.q), 64'h81);
    check("rot l3 done", 64'(bus_r.frame_done), 64'd0);
    drive_r(1'b1, 2'b10, 8'h00); check("rot l4", 64'(bus_r.q), 64'h03);
    check("rot l4 done", 64'(bus_r.frame_done), 64'd0);
    drive_r(1'b1, 2'b10, 8'h00); check("rot l5", 64'(bus_r.q), 64'h06);
    check("rot 8th done", 64'(bus_r.frame_done), 64'd1);
    drive_r(1'b1, 2'b00, 8'h00);
    check("rot done clear", 64'(bus_r.frame_done), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
